// File: rtl/rram_cmd_sequencer_pkg.sv
// Shared encodings and default strobe timing for the RRAM command/address/data
// nibble interface, used by the host sequencer and the chip-side model.
package rram_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CE_LEAD = 3'd1,
        ST_SETUP   = 3'd2,
        ST_WE_LO   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PH_CMD  = 2'd0,
        PH_ADDR = 2'd1,
        PH_DATA = 2'd2
    } phase_e;

    localparam int DEF_ADDR_NIBBLES = 2;
    localparam int DEF_T_SETUP      = 1;
    localparam int DEF_T_WP         = 2;
    localparam int DEF_T_HOLD       = 1;

    // Counter reload for a dwell of t cycles: the counter expires when it reads zero.
    function automatic logic [3:0] reloadVal(input int t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/rram_we_strobe.sv
// Write-strobe timing engine: owns the dwell counter and the transaction state,
// produces WE and flags the end of each nibble's HOLD window.
module rram_we_strobe
    import rram_cmd_sequencer_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_WP    = DEF_T_WP,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_start,
    input  logic   i_more,
    output logic   o_we,
    output state_e o_state,
    output logic   o_loadNibble,
    output logic   o_nibbleDone
);

    state_e     r_state;
    state_e     w_stateNext;
    logic [3:0] r_cnt;
    logic [3:0] w_cntNext;
    logic       r_we;
    logic       w_cntZero;

    assign w_cntZero = (r_cnt == 4'd0);

    // NEXT takes no cycle: the decision to start another nibble or finish is
    // folded into the exit of HOLD.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:    if (i_start)  w_stateNext = ST_CE_LEAD;
            ST_CE_LEAD: if (w_cntZero) w_stateNext = ST_SETUP;
            ST_SETUP:   if (w_cntZero) w_stateNext = ST_WE_LO;
            ST_WE_LO:   if (w_cntZero) w_stateNext = ST_HOLD;
            ST_HOLD:    if (w_cntZero) w_stateNext = i_more ? ST_SETUP : ST_FINISH;
            ST_FINISH:  w_stateNext = ST_IDLE;
            default:    w_stateNext = ST_IDLE;
        endcase

        w_cntNext = w_cntZero ? r_cnt : r_cnt - 4'd1;
        if (w_stateNext != r_state) begin
            case (w_stateNext)
                ST_CE_LEAD, ST_SETUP: w_cntNext = reloadVal(T_SETUP);
                ST_WE_LO:             w_cntNext = reloadVal(T_WP);
                ST_HOLD:              w_cntNext = reloadVal(T_HOLD);
                default:              w_cntNext = 4'd0;
            endcase
        end

        o_loadNibble = (w_stateNext == ST_SETUP) && (r_state != ST_SETUP);
        o_nibbleDone = (r_state == ST_HOLD) && w_cntZero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_we    <= (w_stateNext != ST_WE_LO);
        end
    end

    assign o_we    = r_we;
    assign o_state = r_state;

endmodule

// File: rtl/rram_cmd_sequencer.sv
// Host-side transmitter: accepts one request and serialises command, optional
// address and optional data nibbles onto the chip's IO/CE/WE/CLE/ALE pins.
module rram_cmd_sequencer
    import rram_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES,
    parameter int T_SETUP      = DEF_T_SETUP,
    parameter int T_WP         = DEF_T_WP,
    parameter int T_HOLD       = DEF_T_HOLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [3:0]                req_cmd,
    input  logic                      req_has_addr,
    input  logic [4*ADDR_NIBBLES-1:0] req_addr,
    input  logic                      req_has_data,
    input  logic [3:0]                req_data,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                IO,
    output logic                      CE,
    output logic                      WE,
    output logic                      CLE,
    output logic                      ALE
);

    localparam logic [1:0] LAST_IDX = 2'(ADDR_NIBBLES - 1);

    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;
    logic [3:0]                r_io;
    logic                      r_ce;
    logic                      r_cle;
    logic                      r_ale;
    logic [3:0]                r_cmd;
    logic                      r_hasAddr;
    logic [4*ADDR_NIBBLES-1:0] r_addr;
    logic                      r_hasData;
    logic [3:0]                r_data;
    phase_e                    r_phase;
    logic [1:0]                r_idx;

    logic                      w_accept;
    logic                      w_more;
    logic                      w_loadNibble;
    logic                      w_nibbleDone;
    logic                      w_finish;
    logic                      w_we;
    state_e                    w_state;
    phase_e                    w_nextPhase;
    logic [1:0]                w_nextIdx;
    logic [3:0]                w_nibble;

    assign w_accept = req_valid && r_ready;
    assign w_finish = w_nibbleDone && !w_more;

    rram_we_strobe #(
        .T_SETUP (T_SETUP),
        .T_WP    (T_WP),
        .T_HOLD  (T_HOLD)
    ) u_strobe (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_accept),
        .i_more       (w_more),
        .o_we         (w_we),
        .o_state      (w_state),
        .o_loadNibble (w_loadNibble),
        .o_nibbleDone (w_nibbleDone)
    );

    // Whether another nibble follows the one currently on the bus, and which.
    always_comb begin
        w_more = 1'b0;
        case (r_phase)
            PH_CMD:  w_more = r_hasAddr || r_hasData;
            PH_ADDR: w_more = (r_idx != LAST_IDX) || r_hasData;
            default: w_more = 1'b0;
        endcase

        w_nextPhase = PH_CMD;
        w_nextIdx   = 2'd0;
        if (w_nibbleDone) begin
            case (r_phase)
                PH_CMD:  w_nextPhase = r_hasAddr ? PH_ADDR : PH_DATA;
                PH_ADDR: begin
                    if (r_idx != LAST_IDX) begin
                        w_nextPhase = PH_ADDR;
                        w_nextIdx   = r_idx + 2'd1;
                    end else begin
                        w_nextPhase = PH_DATA;
                    end
                end
                default: w_nextPhase = PH_DATA;
            endcase
        end

        w_nibble = 4'd0;
        case (w_nextPhase)
            PH_CMD:  w_nibble = r_cmd;
            PH_DATA: w_nibble = r_data;
            PH_ADDR: begin
                for (int i = 0; i < ADDR_NIBBLES; i++) begin
                    if (w_nextIdx == 2'(i)) w_nibble = r_addr[4*i +: 4];
                end
            end
            default: w_nibble = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= 4'd0;
            r_hasAddr <= 1'b0;
            r_addr    <= '0;
            r_hasData <= 1'b0;
            r_data    <= 4'd0;
        end else if (w_accept) begin
            r_cmd     <= req_cmd;
            r_hasAddr <= req_has_addr;
            r_addr    <= req_addr;
            r_hasData <= req_has_data;
            r_data    <= req_data;
        end
    end

    // IO/CLE/ALE move only when a SETUP window opens or the transaction finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_io    <= 4'd0;
            r_ce    <= 1'b1;
            r_cle   <= 1'b0;
            r_ale   <= 1'b0;
            r_phase <= PH_CMD;
            r_idx   <= 2'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
                r_ce    <= 1'b0;
            end
            if (w_loadNibble) begin
                r_phase <= w_nextPhase;
                r_idx   <= w_nextIdx;
                r_io    <= w_nibble;
                r_cle   <= (w_nextPhase == PH_CMD);
                r_ale   <= (w_nextPhase == PH_ADDR);
            end
            if (w_finish) begin
                r_ce   <= 1'b1;
                r_cle  <= 1'b0;
                r_ale  <= 1'b0;
                r_io   <= 4'd0;
                r_done <= 1'b1;
            end
            if (w_state == ST_FINISH) begin
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign IO        = r_io;
    assign CE        = r_ce;
    assign WE        = w_we;
    assign CLE       = r_cle;
    assign ALE       = r_ale;

endmodule
